// File: rtl/cvxif_vec_pkg.sv
// Shared types and helpers for the CV-X-IF vector stream coprocessor.
// Result records are sized for the widest supported Xlen and id.
package cvxif_vec_pkg;

  localparam logic [6:0] OPC_CUSTOM3 = 7'b1111011;
  localparam int MAX_XLEN = 64;
  localparam int MAX_ID = 8;

  typedef enum logic [2:0] {
    VADD   = 3'b000,
    VSUB   = 3'b001,
    VXOR   = 3'b010,
    VAND   = 3'b011,
    MV_X_V = 3'b100,
    MV_V_X = 3'b101
  } vec_op_e;

  typedef struct packed {
    logic [MAX_ID-1:0]   id;
    logic [MAX_XLEN-1:0] data;
    logic [4:0]          rd;
    logic                we;
  } vec_result_t;

  function automatic int unsigned idx_width(int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned vlen(logic [6:0] f7,
                                       int unsigned words);
    int unsigned l;
    l = int'(f7) + 1;
    return (l > words) ? words : l;
  endfunction

endpackage

// File: rtl/cvxif_vec_regfile.sv
// Vector register file: flat word array, two async reads, one sync write.
// Not reset; contents survive a coprocessor reset.
module cvxif_vec_regfile #(
  parameter int Xlen  = 64,
  parameter int AW    = 9,
  parameter int Depth = 512
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [Xlen-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr_a,
  output logic [Xlen-1:0] o_rdata_a,
  input  logic [AW-1:0]   i_raddr_b,
  output logic [Xlen-1:0] o_rdata_b
);

  logic [Xlen-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/cvxif_vec_stream_coprocessor.sv
// CV-X-IF vector coprocessor: streams one element per cycle through
// an add/sub/xor/and ALU and moves words to/from the integer file.
module cvxif_vec_stream_coprocessor
  import cvxif_vec_pkg::*;
#(
  parameter int Xlen         = 64,
  parameter int NumVregs     = 32,
  parameter int WordsPerVreg = 16,
  parameter int IdWidth      = 3,
  parameter int ResultDepth  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [Xlen-1:0]    issue_rs1_i,
  input  logic [IdWidth-1:0] issue_id_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [Xlen-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);

  localparam int RW = $clog2(NumVregs);
  localparam int WW = idx_width(WordsPerVreg);
  localparam int AW = RW + WW;
  localparam int PW = (ResultDepth > 1) ? $clog2(ResultDepth) : 1;
  localparam int CW = $clog2(ResultDepth + 1);

  typedef enum logic {S_IDLE, S_EXEC} state_e;

  state_e             r_state;
  vec_op_e            r_op;
  logic [4:0]         r_vd;
  logic [RW-1:0]      r_vs1, r_vs2;
  logic [WW-1:0]      r_w, r_last;
  logic [IdWidth-1:0] r_id;

  vec_result_t        r_q [ResultDepth];
  logic [PW-1:0]      r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]      r_cnt;

  logic [2:0]         w_f3;
  logic               w_known, w_full, w_fire;
  logic               w_mv_fire, w_vec_fire;
  logic               w_exec, w_last_el;
  logic [WW-1:0]      w_idx;
  logic [AW-1:0]      w_raddr_a, w_raddr_b, w_waddr;
  logic [Xlen-1:0]    w_rdata_a, w_rdata_b, w_alu, w_wdata;
  logic               w_we, w_push, w_pop;
  vec_result_t        w_push_data, w_head;

  assign w_f3    = issue_instr_i[14:12];
  assign w_known = (issue_instr_i[6:0] == OPC_CUSTOM3)
                && (w_f3 <= 3'd5);

  assign issue_accept_o    = issue_valid_i && w_known;
  assign issue_writeback_o = issue_accept_o
                          && (w_f3 == 3'(MV_V_X));

  assign w_full        = (r_cnt == CW'(ResultDepth));
  assign issue_ready_o = (r_state == S_IDLE) && !w_full && !rst_i;

  assign w_fire     = issue_valid_i && issue_ready_o && issue_accept_o;
  assign w_mv_fire  = w_fire && w_f3[2];
  assign w_vec_fire = w_fire && !w_f3[2];

  assign w_exec    = (r_state == S_EXEC);
  assign w_last_el = w_exec && (r_w == r_last);
  assign w_idx     = issue_instr_i[20 +: WW];

  assign w_raddr_a = w_exec ? {r_vs1, r_w}
                            : {issue_instr_i[15 +: RW], w_idx};
  assign w_raddr_b = {r_vs2, r_w};

  always_comb begin
    w_alu = '0;
    unique case (r_op)
      VADD:    w_alu = w_rdata_a + w_rdata_b;
      VSUB:    w_alu = w_rdata_a - w_rdata_b;
      VXOR:    w_alu = w_rdata_a ^ w_rdata_b;
      VAND:    w_alu = w_rdata_a & w_rdata_b;
      default: w_alu = '0;
    endcase
  end

  // Writes are gated by reset so an aborted op stops mid-vector.
  assign w_we    = !rst_i && (w_exec
                 || (w_mv_fire && (w_f3 == 3'(MV_X_V))));
  assign w_waddr = w_exec ? {r_vd[RW-1:0], r_w}
                          : {issue_instr_i[7 +: RW], w_idx};
  assign w_wdata = w_exec ? w_alu : issue_rs1_i;

  cvxif_vec_regfile #(
    .Xlen  (Xlen),
    .AW    (AW),
    .Depth (NumVregs * WordsPerVreg)
  ) u_vrf (
    .i_clk     (clk_i),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_raddr_a),
    .o_rdata_a (w_rdata_a),
    .i_raddr_b (w_raddr_b),
    .o_rdata_b (w_rdata_b)
  );

  assign w_push = w_mv_fire || w_last_el;
  assign w_pop  = (r_cnt != '0) && result_ready_i;

  always_comb begin
    w_push_data = '0;
    if (w_exec) begin
      w_push_data.id[IdWidth-1:0] = r_id;
      w_push_data.rd = r_vd;
    end else begin
      w_push_data.id[IdWidth-1:0] = issue_id_i;
      w_push_data.rd = issue_instr_i[11:7];
      if (w_f3 == 3'(MV_V_X)) begin
        w_push_data.we = 1'b1;
        w_push_data.data[Xlen-1:0] = w_rdata_a;
      end
    end
  end

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(ResultDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (w_push) r_q[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_w     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_vec_fire) begin
            r_op    <= vec_op_e'(w_f3);
            r_vd    <= issue_instr_i[11:7];
            r_vs1   <= issue_instr_i[15 +: RW];
            r_vs2   <= issue_instr_i[20 +: RW];
            r_id    <= issue_id_i;
            r_w     <= '0;
            r_last  <= WW'(vlen(issue_instr_i[31:25],
                                WordsPerVreg) - 1);
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_w == r_last) r_state <= S_IDLE;
          else               r_w <= r_w + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_head         = r_q[r_rd_ptr];
  assign result_valid_o = (r_cnt != '0);
  assign result_id_o    = w_head.id[IdWidth-1:0];
  assign result_data_o  = w_head.data[Xlen-1:0];
  assign result_rd_o    = w_head.rd;
  assign result_we_o    = w_head.we;

endmodule
